// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types, opcodes and instruction field positions
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;
endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic: selects jump target, taken-branch target or sequential pc
module next_pc_logic
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [31:0]       instr,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              zero,
  output logic [ADDR_W-1:0] next_pc
);
  logic [ADDR_W-1:0] sext_imm;
  logic unused_opcode;
  assign unused_opcode = ^instr[OPC_HI:OPC_LO];
  assign sext_imm = {{(ADDR_W-16){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
  assign next_pc = Jump ? {pc_plus4[ADDR_W-1:28], instr[TGT_HI:TGT_LO], 2'b00}
                 : (Branch && zero) ? pc_plus4 + (sext_imm << 2)
                 : pc_plus4;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register and req/ack instruction fetch FSM feeding decode
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode_instr,
  input  logic              instr_done,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [31:0]       retired_count
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
  logic [31:0] instr_q, instr_d, retired_count_q, retired_count_d;
  logic retire;
  assign retire = state_q == EXEC && instr_done;
  assign pc_plus4 = pc_q + ADDR_W'(4);
  next_pc_logic #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_plus4(pc_plus4),
    .instr(instr_q),
    .Branch(Branch),
    .Jump(Jump),
    .zero(zero),
    .next_pc(next_pc)
  );
  always_comb begin
    state_d = state_q == IDLE ? FETCH : state_q == FETCH ? (imem_ack ? EXEC : FETCH) : (instr_done ? FETCH : EXEC);
    pc_d = retire ? next_pc : pc_q;
    instr_d = (state_q == FETCH && imem_ack) ? imem_rdata : instr_q;
    retired_count_d = retire ? retired_count_q + 32'd1 : retired_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      instr_q <= '0;
      retired_count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      retired_count_q <= retired_count_d;
    end
  end
  assign imem_req = state_q == FETCH;
  assign instr_valid = state_q == EXEC;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign instr = instr_q;
  assign opcode_instr = instr_q[OPC_HI:OPC_LO];
  assign retired_count = retired_count_q;
endmodule
